// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C target exposing a byte-wide register port.
//   Bus protocol: address byte, pointer byte, then burst data. Writes stream
//   into o_reg_wdata/o_reg_we; reads stream i_reg_rdata out MSB first. The
//   pointer auto-increments (mod 256) after every data byte in either direction.
//   SCL/SDA are oversampled by i_clk (>= 16x SCL); SDA is driven open-drain only
//   and SCL is never stretched.
// Ports:
//   i_clk, i_rst_n     sampling clock, synchronous active-low reset
//   i_scl, i_sda       raw pad values of the bus lines
//   o_sda_oe_n         0 = pull SDA low, 1 = release
//   o_reg_addr         current register pointer
//   o_reg_wdata        write data, valid while o_reg_we=1
//   o_reg_we           one-cycle write strobe
//   i_reg_rdata        read data for o_reg_addr
//   o_busy             high from an addressed START until STOP or release
//   o_nack_seen        one-cycle pulse when the master NACKs a read byte
//   o_state            FSM state, for debug and checker binding
// Register-port handshake: o_reg_we is a single-cycle strobe with no back
// pressure; o_reg_addr/o_reg_wdata are valid in the strobe cycle and the pointer
// advances on the cycle after. i_reg_rdata must be valid for o_reg_addr within
// one cycle of the pointer changing.
module i2c_reg_slave #(
  parameter logic [6:0] SlaveAddress = 7'h5D,
  parameter int         SyncStages   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe_n,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy,
  output logic       o_nack_seen,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t state, state_nxt;

  logic [SyncStages-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [6:0] shift;     // first seven bits of the byte being received
  logic [6:0] tx;        // remaining bits of the byte being transmitted
  logic [2:0] bit_cnt;
  logic       phase;     // ACK states: 1 once the ACK bit slot is entered
  logic       rd_wrn;
  logic [7:0] ptr;
  logic       byte_done;
  logic [7:0] byte_in;

  assign scl_s = scl_sync[SyncStages-1];
  assign sda_s = sda_sync[SyncStages-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SyncStages-2:0], i_scl};
      sda_sync <= {sda_sync[SyncStages-2:0], i_sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SCL must be high on both samples so an SDA edge racing an SCL edge is not
  // mistaken for a bus condition.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_in   = {shift, sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_det) state_nxt = ADDR;
    else if (stop_det) state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE:      state_nxt = IDLE;
        ADDR:      if (byte_done)
                     state_nxt = (byte_in[7:1] == SlaveAddress) ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  if (scl_fall && phase) state_nxt = rd_wrn ? RDATA : PTR;
        PTR:       if (byte_done) state_nxt = PTR_ACK;
        PTR_ACK:   if (scl_fall && phase) state_nxt = WDATA;
        WDATA:     if (byte_done) state_nxt = WDATA_ACK;
        WDATA_ACK: if (scl_fall && phase) state_nxt = WDATA;
        RDATA:     if (scl_fall && bit_cnt == 3'd7) state_nxt = RACK;
        RACK:      if (scl_rise && !phase && sda_s) state_nxt = WAIT_STOP;
                   else if (scl_fall && phase) state_nxt = RDATA;
        WAIT_STOP: state_nxt = WAIT_STOP;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sda_oe_n  <= 1'b1;
      o_reg_wdata <= 8'h00;
      o_reg_we    <= 1'b0;
      o_busy      <= 1'b0;
      o_nack_seen <= 1'b0;
      shift       <= 7'h00;
      tx          <= 7'h7F;
      bit_cnt     <= 3'd0;
      phase       <= 1'b0;
      rd_wrn      <= 1'b0;
      ptr         <= 8'h00;
    end else begin
      o_reg_we    <= 1'b0;
      o_nack_seen <= 1'b0;
      // Write pointer advances the cycle after the strobe so the strobe cycle
      // presents the address the byte belongs to.
      if (o_reg_we) ptr <= ptr + 8'd1;
      if (start_det) begin
        bit_cnt    <= 3'd0;
        phase      <= 1'b0;
        o_sda_oe_n <= 1'b1;
      end else if (stop_det) begin
        bit_cnt    <= 3'd0;
        phase      <= 1'b0;
        o_busy     <= 1'b0;
        o_sda_oe_n <= 1'b1;
      end else begin
        unique case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                phase <= 1'b0;
                if (state == ADDR) begin
                  rd_wrn <= sda_s;
                  o_busy <= (byte_in[7:1] == SlaveAddress);
                end else if (state == PTR) begin
                  ptr <= byte_in;
                end else begin
                  o_reg_wdata <= byte_in;
                  o_reg_we    <= 1'b1;
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            // First fall opens the ACK slot, second fall closes it.
            if (scl_fall) begin
              if (!phase) begin
                phase      <= 1'b1;
                o_sda_oe_n <= 1'b0;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                if (state == ADDR_ACK && rd_wrn) begin
                  tx         <= i_reg_rdata[6:0];
                  o_sda_oe_n <= i_reg_rdata[7];
                end else begin
                  o_sda_oe_n <= 1'b1;
                end
              end
            end
          end
          RDATA: begin
            // Bit 7 went out at load; falls 1..7 shift out bits 6..0, fall 8
            // hands SDA back to the master for its ACK.
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                o_sda_oe_n <= 1'b1;
                phase      <= 1'b0;
              end else begin
                o_sda_oe_n <= tx[6];
                tx         <= {tx[5:0], 1'b1};
              end
            end
          end
          RACK: begin
            if (scl_rise && !phase) begin
              ptr <= ptr + 8'd1;
              if (sda_s) o_nack_seen <= 1'b1;
              else       phase       <= 1'b1;
            end else if (scl_fall && phase) begin
              // Pointer moved at the ACK rise, so rdata is for the new address.
              phase      <= 1'b0;
              bit_cnt    <= 3'd0;
              tx         <= i_reg_rdata[6:0];
              o_sda_oe_n <= i_reg_rdata[7];
            end
          end
          WAIT_STOP: o_sda_oe_n <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign o_reg_addr = ptr;
  assign o_state    = state;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: bit-banged I2C master driving i2c_reg_slave, with a
// transaction-level model (expected pointer, expected register contents,
// expected write queue, expected NACK count) and a per-cycle compare process.
module tb_i2c_reg_slave;

  localparam logic [6:0] SLAVE = 7'h5D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       o_sda_oe_n, o_reg_we, o_busy, o_nack_seen;
  logic [7:0] o_reg_addr, o_reg_wdata, i_reg_rdata;
  logic [3:0] o_state;

  assign sda_bus = m_sda & o_sda_oe_n;

  i2c_reg_slave #(.SlaveAddress(SLAVE), .SyncStages(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_scl       (m_scl),
    .i_sda       (sda_bus),
    .o_sda_oe_n  (o_sda_oe_n),
    .o_reg_addr  (o_reg_addr),
    .o_reg_wdata (o_reg_wdata),
    .o_reg_we    (o_reg_we),
    .i_reg_rdata (i_reg_rdata),
    .o_busy      (o_busy),
    .o_nack_seen (o_nack_seen),
    .o_state     (o_state)
  );

  // Register file the DUT talks to (stimulus side).
  logic [7:0] reg_file [256];
  assign i_reg_rdata = reg_file[o_reg_addr];
  always @(posedge clk) if (o_reg_we) reg_file[o_reg_addr] <= o_reg_wdata;

  // ---------------- model / scoreboard ----------------
  logic [7:0]  model_mem [256];
  logic [7:0]  exp_ptr;
  logic [15:0] exp_q[$];   // {addr, data} of each write the DUT must strobe
  logic [15:0] got_q[$];   // writes actually observed
  logic [7:0]  rd_log[$];
  logic [7:0]  wbuf [4];
  int          exp_nack = 0;
  int          nack_cnt = 0;
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  bit          quiet = 1'b0;
  int          q = 5;      // quarter SCL period in clk cycles

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_reg_we) begin
        got_q.push_back({o_reg_addr, o_reg_wdata});
        if (exp_q.size() == 0) chk("unexpected_we", {o_reg_addr, o_reg_wdata}, 16'h0000);
        else chk("we_addr_data", {o_reg_addr, o_reg_wdata}, exp_q.pop_front());
      end
      if (o_nack_seen) nack_cnt++;
      if (quiet) begin
        chk("quiet_oe_n", {15'd0, o_sda_oe_n}, 16'd1);
        chk("quiet_busy", {15'd0, o_busy}, 16'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(q);
    m_scl = 1'b1; tick(q);
    m_sda = 1'b0; tick(q);
    m_scl = 1'b0; tick(q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(q);
    m_scl = 1'b1; tick(q);
    m_sda = 1'b1; tick(q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; tick(q);
    m_scl = 1'b1; tick(2 * q);
    m_scl = 1'b0; tick(q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(q);
    m_scl = 1'b1; tick(q);
    b = sda_bus; tick(q);
    m_scl = 1'b0; tick(q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic do_write(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] p;
    bus_start();
    write_byte({SLAVE, 1'b0}, a); chk("addr_ack", {15'd0, a}, 16'd0);
    chk("busy_addressed", {15'd0, o_busy}, 16'd1);
    write_byte(ptr, a); chk("ptr_ack", {15'd0, a}, 16'd0);
    p = ptr;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, wbuf[i]});
      model_mem[p] = wbuf[i];
      write_byte(wbuf[i], a); chk("data_ack", {15'd0, a}, 16'd0);
      p = p + 8'd1;
    end
    bus_stop();
    exp_ptr = p;
    tick(4);
    chk("ptr_after_write", {8'd0, o_reg_addr}, {8'd0, exp_ptr});
    chk("busy_after_stop", {15'd0, o_busy}, 16'd0);
  endtask

  task automatic do_read(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] p, v;
    bus_start();
    write_byte({SLAVE, 1'b0}, a); chk("rd_setup_addr_ack", {15'd0, a}, 16'd0);
    write_byte(ptr, a); chk("rd_setup_ptr_ack", {15'd0, a}, 16'd0);
    bus_start();
    write_byte({SLAVE, 1'b1}, a); chk("rd_addr_ack", {15'd0, a}, 16'd0);
    p = ptr;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, v);
      chk("rdata", {8'd0, v}, {8'd0, model_mem[p]});
      rd_log.push_back(v);
      p = p + 8'd1;
    end
    exp_nack++;
    bus_stop();
    exp_ptr = p;
    tick(4);
    chk("ptr_after_read", {8'd0, o_reg_addr}, {8'd0, exp_ptr});
    chk("busy_after_read", {15'd0, o_busy}, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a, b;
    for (int i = 0; i < 256; i++) begin
      reg_file[i]  = 8'(i) ^ 8'hFF;
      model_mem[i] = 8'(i) ^ 8'hFF;
    end
    exp_ptr = 8'h00;
    tick(4);
    chk("rst_oe_n", {15'd0, o_sda_oe_n}, 16'd1);
    chk("rst_addr", {8'd0, o_reg_addr}, 16'd0);
    chk("rst_we", {15'd0, o_reg_we}, 16'd0);
    chk("rst_busy", {15'd0, o_busy}, 16'd0);
    chk("rst_nack", {15'd0, o_nack_seen}, 16'd0);
    rst_n = 1'b1;
    tick(4);

    // 1: burst write of two bytes at 0x10
    got_q.delete();
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write(8'h10, 2);
    chk("t1_nwrites", 16'(got_q.size()), 16'd2);
    chk("t1_write0", got_q[0], 16'h10A5);
    chk("t1_write1", got_q[1], 16'h113C);
    chk("t1_ptr", {8'd0, o_reg_addr}, 16'h0012);

    // 2: read three bytes from 0x20, last one NACKed
    rd_log.delete();
    do_read(8'h20, 3);
    chk("t2_byte0", {8'd0, rd_log[0]}, 16'h00DF);
    chk("t2_byte1", {8'd0, rd_log[1]}, 16'h00DE);
    chk("t2_byte2", {8'd0, rd_log[2]}, 16'h00DD);
    chk("t2_nack_pulses", 16'(nack_cnt), 16'd1);
    chk("t2_ptr", {8'd0, o_reg_addr}, 16'h0023);

    // 3: foreign address, slave must stay off the bus
    quiet = 1'b1;
    bus_start();
    write_byte({7'h50, 1'b0}, a); chk("t3_addr_nack", {15'd0, a}, 16'd1);
    write_byte(8'h12, a);         chk("t3_data0_nack", {15'd0, a}, 16'd1);
    write_byte(8'h34, a);         chk("t3_data1_nack", {15'd0, a}, 16'd1);
    bus_stop();
    quiet = 1'b0;
    tick(4);
    chk("t3_ptr_kept", {8'd0, o_reg_addr}, {8'd0, exp_ptr});

    // 4: pointer wrap
    got_q.delete();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'hFF, 2);
    chk("t4_write0", got_q[0], 16'hFF11);
    chk("t4_write1", got_q[1], 16'h0022);
    chk("t4_ptr", {8'd0, o_reg_addr}, 16'h0001);

    // 5: reset while the slave holds SDA low during a read (0x40 -> 0xBF, bit6=0)
    bus_start();
    write_byte({SLAVE, 1'b0}, a); chk("t5_addr_ack", {15'd0, a}, 16'd0);
    write_byte(8'h40, a);         chk("t5_ptr_ack", {15'd0, a}, 16'd0);
    bus_start();
    write_byte({SLAVE, 1'b1}, a); chk("t5_rd_ack", {15'd0, a}, 16'd0);
    read_bit(b); chk("t5_bit7", {15'd0, b}, 16'd1);
    m_sda = 1'b1; tick(q);
    m_scl = 1'b1; tick(q);
    chk("t5_sda_low", {15'd0, sda_bus}, 16'd0);
    rst_n = 1'b0;
    tick(1);
    chk("t5_release", {15'd0, o_sda_oe_n}, 16'd1);
    chk("t5_ptr_reset", {8'd0, o_reg_addr}, 16'd0);
    tick(2);
    rst_n = 1'b1;
    exp_ptr = 8'h00;
    m_scl = 1'b0; tick(q);
    bus_stop();
    tick(4);
    got_q.delete();
    wbuf[0] = 8'h77;
    do_write(8'h05, 1);
    chk("t5_write", got_q[0], 16'h0577);

    // 6: slower bus (250 kHz SCL at 10 MHz clk), write then read back 4 bytes
    q = 10;
    wbuf[0] = 8'hC3; wbuf[1] = 8'h5A; wbuf[2] = 8'h96; wbuf[3] = 8'h0F;
    do_write(8'h80, 4);
    rd_log.delete();
    do_read(8'h80, 4);
    chk("t6_rb0", {8'd0, rd_log[0]}, 16'h00C3);
    chk("t6_rb3", {8'd0, rd_log[3]}, 16'h000F);

    tick(10);
    chk("we_queue_drained", 16'(exp_q.size()), 16'd0);
    chk("nack_total", 16'(nack_cnt), 16'(exp_nack));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
